// File: rtl/sdram_cmd_scheduler.sv
// Single-request closed-page SDRAM command scheduler: power-up init, periodic
// auto-refresh, and one READ/WRITE per accepted request with auto-precharge.
module sdram_cmd_scheduler #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int COL_BITS   = 9,
  parameter int ROW_BITS   = 13,
  parameter int BANK_BITS  = 2,
  parameter int T_INIT     = 10000,
  parameter int T_RP       = 2,
  parameter int T_RCD      = 2,
  parameter int T_RFC      = 7,
  parameter int T_REF      = 780,
  parameter int CAS_LAT    = 2,
  parameter int T_WR       = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  req_valid_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  wdata_valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_valid_o,
  output logic                  error_o,
  output logic                  sd_cke,
  output logic                  sd_cs_n,
  output logic                  sd_ras_n,
  output logic                  sd_cas_n,
  output logic                  sd_we_n,
  output logic [BANK_BITS-1:0]  sd_ba,
  output logic [ROW_BITS-1:0]   sd_a,
  output logic [DATA_WIDTH-1:0] sd_dq_o,
  output logic                  sd_dq_oe,
  input  logic [DATA_WIDTH-1:0] sd_dq_i
);
  localparam int TMAX     = (T_INIT > T_REF) ? T_INIT : T_REF;
  localparam int CW       = $clog2(TMAX + 1) + 1;
  localparam int BANK_LO  = COL_BITS + 2;
  localparam int ROW_LO   = BANK_LO + BANK_BITS;
  localparam int ADDR_TOP = ROW_LO + ROW_BITS;

  localparam logic [3:0] CMD_NOP = 4'b0111, CMD_ACT = 4'b0011, CMD_RD  = 4'b0101,
                         CMD_WR  = 4'b0100, CMD_PRE = 4'b0010, CMD_REF = 4'b0001,
                         CMD_MRS = 4'b0000;

  localparam logic [CW-1:0] END_INIT   = CW'(T_INIT);
  localparam logic [CW-1:0] END_RP     = CW'(T_RP - 1);
  localparam logic [CW-1:0] END_RFC    = CW'(T_RFC - 1);
  localparam logic [CW-1:0] END_RCD    = CW'(T_RCD - 1);
  localparam logic [CW-1:0] END_CL     = CW'(CAS_LAT - 1);
  localparam logic [CW-1:0] END_MRS    = CW'(1);
  localparam logic [CW-1:0] END_WREC   = CW'(T_WR + T_RP - 1);
  // read recovery also covers the cycle that presents rdata_o
  localparam logic [CW-1:0] END_RREC   = CW'(T_RP);
  localparam logic [CW-1:0] REF_RELOAD = CW'(T_REF - 1);
  localparam logic [ROW_BITS-1:0] MODE_REG = ROW_BITS'((CAS_LAT & 7) << 4);

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
    S_IDLE, S_REFRESH, S_ACTIVATE, S_RW, S_RD_LAT, S_RECOVER
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, ref_q;
  logic                  pend_q;
  logic [3:0]            cmd_q, cmd_d;
  logic [BANK_BITS-1:0]  ba_q, ba_d, bank_q;
  logic [ROW_BITS-1:0]   a_q, a_d, row_q;
  logic [COL_BITS-1:0]   col_q;
  logic                  wr_q, cke_q, oe_q, oe_d;
  logic [DATA_WIDTH-1:0] wdat_q, dqo_q, dqo_d, cap_q, rdata_q;
  logic                  cap_vld_q, cap_vld_d, rvld_q, err_q, err_d;
  logic                  ref_run, ref_exp, pend_any, oor, accept, clr_pend, ref_load;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^req_addr_i[1:0];

  // an expiry in the current cycle already outranks a request
  assign ref_run  = (state_q > S_INIT_MRS);
  assign ref_exp  = ref_run && (ref_q == '0);
  assign pend_any = pend_q | ref_exp;
  assign oor      = (req_addr_i >> ADDR_TOP) != '0;
  assign ready_o  = (state_q == S_IDLE) && !pend_any && (!req_write_i || wdata_valid_i);
  assign accept   = req_valid_i && ready_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    cmd_d     = CMD_NOP;
    ba_d      = '0;
    a_d       = '0;
    oe_d      = 1'b0;
    dqo_d     = '0;
    cap_vld_d = 1'b0;
    err_d     = 1'b0;
    clr_pend  = 1'b0;
    ref_load  = 1'b0;
    case (state_q)
      S_INIT_WAIT: if (cnt_q == END_INIT) begin
        state_d = S_INIT_PRE; cnt_d = '0; cmd_d = CMD_PRE; a_d[10] = 1'b1;
      end
      S_INIT_PRE: if (cnt_q == END_RP) begin
        state_d = S_INIT_REF1; cnt_d = '0; cmd_d = CMD_REF;
      end
      S_INIT_REF1: if (cnt_q == END_RFC) begin
        state_d = S_INIT_REF2; cnt_d = '0; cmd_d = CMD_REF;
      end
      S_INIT_REF2: if (cnt_q == END_RFC) begin
        state_d = S_INIT_MRS; cnt_d = '0; cmd_d = CMD_MRS; a_d = MODE_REG;
      end
      S_INIT_MRS: if (cnt_q == END_MRS) begin
        state_d = S_IDLE; cnt_d = '0; ref_load = 1'b1;
      end
      S_IDLE: begin
        cnt_d = '0;
        if (pend_any) begin
          state_d = S_REFRESH; cmd_d = CMD_REF; clr_pend = 1'b1;
        end else if (accept) begin
          if (oor) begin
            err_d = 1'b1;
          end else begin
            state_d = S_ACTIVATE; cmd_d = CMD_ACT;
            ba_d    = req_addr_i[BANK_LO +: BANK_BITS];
            a_d     = req_addr_i[ROW_LO +: ROW_BITS];
          end
        end
      end
      S_REFRESH: if (cnt_q == END_RFC) begin
        state_d = S_IDLE; cnt_d = '0;
      end
      S_ACTIVATE: if (cnt_q == END_RCD) begin
        state_d = S_RW; cnt_d = '0;
        cmd_d   = wr_q ? CMD_WR : CMD_RD;
        ba_d    = bank_q;
        a_d     = ROW_BITS'(col_q);
        a_d[10] = 1'b1;
        oe_d    = wr_q;
        dqo_d   = wr_q ? wdat_q : '0;
      end
      S_RW: begin
        state_d = wr_q ? S_RECOVER : S_RD_LAT; cnt_d = '0;
      end
      S_RD_LAT: if (cnt_q == END_CL) begin
        state_d = S_RECOVER; cnt_d = '0; cap_vld_d = 1'b1;
      end
      S_RECOVER: if (cnt_q == (wr_q ? END_WREC : END_RREC)) begin
        state_d = S_IDLE; cnt_d = '0;
      end
      default: state_d = S_INIT_WAIT;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_INIT_WAIT; cnt_q <= '0; ref_q <= '0; pend_q <= 1'b0;
      cke_q <= 1'b0; cmd_q <= CMD_NOP; ba_q <= '0; a_q <= '0;
      oe_q <= 1'b0; dqo_q <= '0; cap_q <= '0; cap_vld_q <= 1'b0;
      rdata_q <= '0; rvld_q <= 1'b0; err_q <= 1'b0;
      row_q <= '0; bank_q <= '0; col_q <= '0; wr_q <= 1'b0; wdat_q <= '0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d;
      cke_q <= 1'b1; cmd_q <= cmd_d; ba_q <= ba_d; a_q <= a_d;
      oe_q <= oe_d; dqo_q <= dqo_d; err_q <= err_d;
      if (ref_load)     ref_q <= REF_RELOAD;
      else if (ref_run) ref_q <= ref_exp ? REF_RELOAD : ref_q - 1'b1;
      pend_q <= (pend_q | ref_exp) & ~clr_pend;
      if (accept) begin
        row_q  <= req_addr_i[ROW_LO +: ROW_BITS];
        bank_q <= req_addr_i[BANK_LO +: BANK_BITS];
        col_q  <= req_addr_i[2 +: COL_BITS];
        wr_q   <= req_write_i;
        wdat_q <= wdata_i;
      end
      // capture edge, then one more register stage to the user port
      cap_vld_q <= cap_vld_d;
      if (cap_vld_d) cap_q <= sd_dq_i;
      rvld_q <= cap_vld_q;
      if (cap_vld_q) rdata_q <= cap_q;
    end
  end

  assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd_q;
  assign sd_cke        = cke_q;
  assign sd_ba         = ba_q;
  assign sd_a          = a_q;
  assign sd_dq_o       = dqo_q;
  assign sd_dq_oe      = oe_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvld_q;
  assign error_o       = err_q;
endmodule

// File: tb/tb_sdram_cmd_scheduler.sv
// Directed bench for sdram_cmd_scheduler with short init and refresh intervals.
module tb_sdram_cmd_scheduler;
  localparam int T_INIT = 16, T_REF = 60, T_RFC = 7, CL = 2;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100,
                         PRE = 4'b0010, REF = 4'b0001, MRS = 4'b0000;

  logic        HCLK, HRESETn;
  logic        req_valid_i, req_write_i, wdata_valid_i;
  logic [31:0] req_addr_i, wdata_i, sd_dq_i;
  logic        ready_o, rdata_valid_o, error_o;
  logic [31:0] rdata_o, sd_dq_o;
  logic        sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_dq_oe;
  logic [1:0]  sd_ba;
  logic [12:0] sd_a;
  logic [3:0]  cmd;

  int checks = 0, passes = 0, cyc_n = 0;

  assign cmd = {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n};

  sdram_cmd_scheduler #(.T_INIT(T_INIT), .T_REF(T_REF), .T_RFC(T_RFC), .CAS_LAT(CL)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_write_i(req_write_i),
    .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .ready_o(ready_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .error_o(error_o),
    .sd_cke(sd_cke), .sd_cs_n(sd_cs_n), .sd_ras_n(sd_ras_n), .sd_cas_n(sd_cas_n),
    .sd_we_n(sd_we_n), .sd_ba(sd_ba), .sd_a(sd_a), .sd_dq_o(sd_dq_o),
    .sd_dq_oe(sd_dq_oe), .sd_dq_i(sd_dq_i)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge HCLK); #1; cyc_n++;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 50 && !ready_o; k++) cyc();
    chk("wait_ready", ready_o, 1'b1);
  endtask

  task automatic init_seq(input string tag);
    logic [3:0] exp;
    for (int c = 1; c <= T_INIT + 2 + 2*T_RFC + 3; c++) begin
      cyc();
      exp = NOP;
      if (c == 17) exp = PRE;
      if (c == 19 || c == 26) exp = REF;
      if (c == 33) exp = MRS;
      chk({tag, "_cmd"}, cmd, exp);
      if (c == 1)  chk({tag, "_cke"}, sd_cke, 1'b1);
      if (c == 17) chk({tag, "_pre_a10"}, sd_a[10], 1'b1);
      if (c == 33) chk({tag, "_mrs_a"}, sd_a, 13'h020);
      if (c == 34) chk({tag, "_not_ready"}, ready_o, 1'b0);
      if (c == 35) chk({tag, "_ready"}, ready_o, 1'b1);
    end
  endtask

  initial begin
    int act_c, bad;
    HRESETn = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0; wdata_valid_i = 1'b0;
    req_addr_i = '0; wdata_i = '0; sd_dq_i = '0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_cke", sd_cke, 1'b0);
    chk("rst_cmd", cmd, NOP);
    chk("rst_a", {sd_ba, sd_a}, 15'h0);
    chk("rst_dq", {sd_dq_oe, sd_dq_o}, 33'h0);
    chk("rst_strobes", {rdata_valid_o, error_o, ready_o}, 3'b000);
    chk("rst_rdata", rdata_o, 32'h0);
    HRESETn = 1'b1; cyc_n = 0;
    init_seq("init");

    // 0x1004: col=1, bank=2 (addr bit 12), row=0
    req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h0000_1004;
    wdata_i = 32'hDEADBEEF; wdata_valid_i = 1'b0;
    #1 chk("wr_no_wdata_ready", ready_o, 1'b0);
    wdata_valid_i = 1'b1;
    #1 chk("wr_wdata_ready", ready_o, 1'b1);
    cyc(); req_valid_i = 1'b0;
    chk("wr_act", cmd, ACT);
    chk("wr_act_addr", {sd_ba, sd_a}, {2'd2, 13'd0});
    cyc(); chk("wr_rcd_nop", cmd, NOP);
    cyc();
    chk("wr_cmd", cmd, WR);
    chk("wr_col_a10", {sd_ba, sd_a}, {2'd2, 13'h401});
    chk("wr_dq", {sd_dq_oe, sd_dq_o}, {1'b1, 32'hDEADBEEF});
    cyc(); chk("wr_oe_drop", sd_dq_oe, 1'b0);
    req_write_i = 1'b0; wdata_valid_i = 1'b0;
    repeat (3) cyc();
    chk("wr_recover_busy", ready_o, 1'b0);
    cyc(); chk("wr_recover_done", ready_o, 1'b1);

    req_valid_i = 1'b1; req_addr_i = 32'h0000_1004;
    cyc(); req_valid_i = 1'b0;
    chk("rd_act", cmd, ACT);
    cyc(); cyc();
    chk("rd_cmd", cmd, RD);
    chk("rd_col_a10", {sd_ba, sd_a, sd_dq_oe}, {2'd2, 13'h401, 1'b0});
    repeat (CL) cyc();
    sd_dq_i = 32'hCAFEF00D;
    cyc(); sd_dq_i = '0;
    chk("rd_not_yet", rdata_valid_o, 1'b0);
    cyc();
    chk("rd_valid_at_6", rdata_valid_o, 1'b1);
    chk("rd_data", rdata_o, 32'hCAFEF00D);
    cyc(); chk("rd_valid_pulse", rdata_valid_o, 1'b0);

    wait_ready();
    req_valid_i = 1'b1; req_addr_i = 32'h1000_0000;
    cyc(); req_valid_i = 1'b0;
    chk("oor_err", error_o, 1'b1);
    chk("oor_no_cmd", cmd, NOP);
    chk("oor_ready", ready_o, 1'b1);
    cyc(); chk("oor_err_pulse", {error_o, cmd}, {1'b0, NOP});

    req_valid_i = 1'b1; req_addr_i = 32'h03FF_FFFC;
    cyc(); req_valid_i = 1'b0;
    chk("top_in_range", {error_o, cmd}, {1'b0, ACT});
    chk("top_act_addr", {sd_ba, sd_a}, {2'd3, 13'h1FFF});
    wait_ready();
    req_valid_i = 1'b1; req_addr_i = 32'h0400_0000;
    cyc(); req_valid_i = 1'b0;
    chk("bit26_err", {error_o, cmd}, {1'b1, NOP});

    // timer loads at cycle 35, so cycle 94 is the first expiry
    while (cyc_n < 93) cyc();
    chk("on_time", cyc_n, 93);
    chk("pre_ref_ready", ready_o, 1'b1);
    cyc();
    req_valid_i = 1'b1; req_addr_i = 32'h0000_1004;
    #1 chk("expiry_blocks_req", ready_o, 1'b0);
    cyc(); chk("ref_first", cmd, REF);
    act_c = 0;
    for (int k = 0; k < 20 && act_c == 0; k++) begin
      cyc();
      if (cmd == ACT) act_c = cyc_n;
    end
    req_valid_i = 1'b0;
    chk("act_after_trfc", (act_c >= 95 + T_RFC), 1'b1);
    wait_ready();

    req_valid_i = 1'b1; req_addr_i = 32'h0000_2008;
    cyc(); req_valid_i = 1'b0;
    chk("rst_rd_act", {cmd, sd_a}, {ACT, 13'd1});
    cyc(); cyc();
    chk("rst_rd_cmd", {cmd, sd_a}, {RD, 13'h402});
    cyc();
    HRESETn = 1'b0; sd_dq_i = 32'h1234_5678;
    #1 chk("mid_rst_outputs", {sd_cke, cmd, ready_o}, {1'b0, NOP, 1'b0});
    bad = 0;
    repeat (4) begin
      cyc();
      if (rdata_valid_o || error_o) bad++;
    end
    HRESETn = 1'b1; cyc_n = 0;
    for (int c = 0; c < 6; c++) begin
      if (rdata_valid_o || error_o) bad++;
      if (c == 2) sd_dq_i = '0;
      cyc();
    end
    chk("mid_rst_no_strobe", bad, 0);
    chk("reinit_waiting", {ready_o, cmd}, {1'b0, NOP});
    while (cyc_n < 16) cyc();
    cyc(); chk("reinit_pre", {cmd, sd_a[10]}, {PRE, 1'b1});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
